// File: rtl/counter_rr_scheduler.sv
// rtl/counter_rr_scheduler.sv - round-robin sharing of one mod-2^CW counter among NREQ requesters
// Optional CNT_HOLD_EN adds a hold input that freezes the count and stretches the slot.
module counter_rr_scheduler #(
  parameter int NREQ     = 4,
  parameter int CW       = 3,
  parameter int SLOT_LEN = 8,
  localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
`ifdef CNT_HOLD_EN
  input  logic            hold,
`endif
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [OW-1:0]   owner,
  output logic [CW-1:0]   count,
  output logic            slot_done
);

  localparam logic [CW-1:0] LAST = CW'(SLOT_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_d;
  logic [NREQ-1:0] gnt_d;
  logic [CW-1:0]   count_d;
  logic            hold_eff;
  logic            owner_req;
  logic            at_last;
  logic            found;
  logic [OW-1:0]   pick;
  logic [OW-1:0]   cand;

`ifdef CNT_HOLD_EN
  assign hold_eff = hold;
`else
  assign hold_eff = 1'b0;
`endif

  assign busy      = (state_q == RUN);
  assign owner_req = req[owner];
  assign at_last   = (count == LAST);
  assign slot_done = busy && owner_req && at_last && !hold_eff;

  // Search starts just past the last grantee so the previous owner is considered last.
  always_comb begin
    found = 1'b0;
    pick  = owner;
    cand  = owner;
    for (int i = 1; i <= NREQ; i++) begin
      cand = OW'((int'(owner) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner;
    gnt_d   = gnt;
    count_d = count;
    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        count_d = '0;
        if (found) begin
          state_d = RUN;
          owner_d = pick;
          gnt_d   = NREQ'(1) << pick;
        end
      end
      RUN: begin
        if (!owner_req || (at_last && !hold_eff)) begin
          state_d = IDLE;
          gnt_d   = '0;
          count_d = '0;
        end else if (!hold_eff) begin
          count_d = count + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner   <= OW'(NREQ - 1);
      gnt     <= '0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      owner   <= owner_d;
      gnt     <= gnt_d;
      count   <= count_d;
    end
  end

endmodule
